workout_time_calc: RTL and testbench
====================================

WORKOUT_TIME_CALC -- requirements
Module: workout_time_calc

Interface
REQ-001 Parameter WEIGHT_W, default 8: width of the weight input, in kg.
REQ-002 Parameter CAL_W, default 9: width of the calorie target, in kcal.
REQ-003 Parameter MET_W, default 5: width of the MET input, in half-MET units.
REQ-004 Parameter T_W, default 8: width of the result, in minutes.
REQ-005 Port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-006 Port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-007 Port in_valid, input, 1 bit: request valid.
REQ-008 Port in_ready, output, 1 bit: block can accept a request.
REQ-009 Port weight_in, input, WEIGHT_W bits: body weight in kg, unsigned.
REQ-010 Port cal_in, input, CAL_W bits: calorie target in kcal, unsigned.
REQ-011 Port met_x2_in, input, MET_W bits: 2 x MET, unsigned.
REQ-012 Port gender_in, input, 1 bit: 0 selects factor 1.0; 1 selects factor 1.125.
REQ-013 Port out_valid, output, 1 bit: result valid.
REQ-014 Port out_ready, input, 1 bit: consumer accepts the result.
REQ-015 Port t_out, output, T_W bits: exercise time in minutes.
REQ-016 Port sat_out, output, 1 bit: the quotient exceeded 2^T_W-1.
REQ-017 Port err_out, output, 1 bit: the denominator was zero.

Function
REQ-018 The block SHALL compute T = (cal x 6400) / (7 x met_x2 x weight x G8), where G8 = 8 when gender_in = 0 and G8 = 9 when gender_in = 1.
REQ-019 The numerator width SHALL be NW = CAL_W + 14; all products SHALL be full width, with no intermediate truncation.
REQ-020 The FSM SHALL have four states: IDLE, PREP, DIV, DONE.
- IDLE -> PREP on in_valid & in_ready.
- PREP -> DIV after 1 cycle.
- DIV -> DONE after exactly NW cycles.
- DONE -> IDLE on out_ready.
REQ-021 in_ready SHALL be high only in IDLE; all inputs SHALL be registered on the accept edge, and later input changes SHALL be ignored.
REQ-022 In PREP the block SHALL form the numerator N and the denominator D from the registered inputs.
REQ-023 In DIV the block SHALL run a restoring divider that produces one quotient bit per cycle, MSB first.
REQ-024 out_valid SHALL rise NW+1 cycles after the accept edge (24 cycles at the defaults) and SHALL stay high in DONE.
REQ-025 t_out, sat_out and err_out SHALL stay stable while out_valid is high.
REQ-026 If the quotient exceeds 2^T_W-1, t_out SHALL be all ones and sat_out SHALL be 1.
REQ-027 If D = 0 (weight = 0 or met_x2 = 0), the block SHALL skip the division and go PREP -> DONE, with t_out all ones, err_out = 1 and sat_out = 0.
REQ-028 With out_ready held high, DONE SHALL last 1 cycle; in_ready SHALL reassert on the next cycle; there SHALL be no back-to-back overlap between requests.
REQ-029 An in_valid that arrives while the block is busy SHALL remain pending, with no loss, until in_ready is high.

Reset
REQ-030 While rst_n = 0, the block SHALL hold state = IDLE, in_ready = 1, out_valid = 0, t_out = 0, sat_out = 0 and err_out = 0.
REQ-031 A reset during PREP, DIV or DONE SHALL abort the computation immediately; no partial result SHALL appear after release.
REQ-032 The block SHALL accept a request on the first rising edge after rst_n deasserts.

Configuration
REQ-033 With macro WORKOUT_ROUND_EN defined, the block SHALL add D>>1 to N before dividing, so the result rounds to nearest with halves rounding up.
REQ-034 Without WORKOUT_ROUND_EN, the quotient SHALL truncate.
REQ-035 WORKOUT_ROUND_EN SHALL not change latency or interface.

Structure
REQ-036 A shared package workout_pkg SHALL hold the FSM state enum, the constants 6400, 7, and G8 = 8/9, and the derivation of NW.
REQ-037 The divider SHALL be a sub-module seq_divider (start/busy/done, parametrised width, with a zero-divisor flag); the top level SHALL hold the FSM, the operand preparation and the saturation logic.

Verification
REQ-038 W=70, Cal=100, met_x2=8, G=0 (D=31360) -> t_out=20 in both modes; sat=0; err=0; out_valid exactly 24 cycles after accept.
REQ-039 W=70, Cal=100, met_x2=8, G=1 (D=35280) -> t_out=18 in both modes.
REQ-040 W=50, Cal=200, met_x2=2, G=0 (D=5600) -> t_out=228 without WORKOUT_ROUND_EN; t_out=229 with it.
REQ-041 W=50, Cal=300, met_x2=2, G=0 (quotient 342) -> t_out=255, sat_out=1.
REQ-042 W=0, Cal=100, met_x2=8 -> t_out=255, err_out=1, out_valid 1 cycle after accept.
REQ-043 Assert rst_n=0 at cycle 10 of DIV, then release -> out_valid=0 and in_ready=1 throughout; the next request gives a correct result.
REQ-044 Hold out_ready=0 for 5 cycles in DONE -> outputs stable and in_ready=0; a pending in_valid is accepted only after DONE -> IDLE.

Source files
------------

// File: rtl/workout_pkg.sv
// ------------------------------------------------------------------
// workout_pkg: shared FSM states, scaling constants and width helpers
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

package workout_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PREP = 2'd1,
    DIV  = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam int unsigned CAL_SCALE = 6400;
  localparam int unsigned MET_SCALE = 7;
  localparam int unsigned G8_MALE   = 8;
  localparam int unsigned G8_FEMALE = 9;

  // 6400 needs 13 bits; one extra bit leaves headroom for the rounding term.
  function automatic int unsigned calc_nw(input int unsigned cal_w);
    return cal_w + 14;
  endfunction

  // 7 needs 3 bits and G8 (max 9) needs 4 bits.
  function automatic int unsigned calc_dw(input int unsigned met_w, input int unsigned weight_w);
    return met_w + weight_w + 7;
  endfunction

endpackage

`default_nettype wire

// File: rtl/seq_divider.sv
// ------------------------------------------------------------------
// seq_divider: restoring divider, one quotient bit per cycle, MSB first
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module seq_divider #(
  parameter int unsigned N_W = 23,
  parameter int unsigned D_W = 20
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [N_W-1:0] dividend,
  input  logic [D_W-1:0] divisor,
  output logic           busy,
  output logic           done,
  output logic [N_W-1:0] quotient,
  output logic           zero
);

  localparam int unsigned CNT_W = $clog2(N_W + 1);

  logic [N_W-1:0]   quo_q;
  logic [D_W-1:0]   rem_q;
  logic [D_W-1:0]   dsr_q;
  logic [CNT_W-1:0] cnt_q;
  logic             busy_q;

  logic [D_W:0]     partial;
  logic [D_W:0]     diff;
  logic             qbit;
  logic [D_W-1:0]   rem_next;

  // partial < 2*divisor always, so the borrow bit alone decides the quotient bit.
  always_comb begin
    partial  = {rem_q, quo_q[N_W-1]};
    diff     = partial - {1'b0, dsr_q};
    qbit     = ~diff[D_W];
    rem_next = qbit ? diff[D_W-1:0] : partial[D_W-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      quo_q  <= '0;
      rem_q  <= '0;
      dsr_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
    end else if (start && !zero && !busy_q) begin
      quo_q  <= dividend;
      rem_q  <= '0;
      dsr_q  <= divisor;
      cnt_q  <= CNT_W'(N_W);
      busy_q <= 1'b1;
    end else if (busy_q) begin
      quo_q <= {quo_q[N_W-2:0], qbit};
      rem_q <= rem_next;
      cnt_q <= cnt_q - CNT_W'(1);
      if (cnt_q == CNT_W'(1)) begin
        busy_q <= 1'b0;
      end
    end
  end

  // done marks the cycle performing the final step; quotient is complete after it.
  assign busy     = busy_q;
  assign done     = busy_q && (cnt_q == CNT_W'(1));
  assign quotient = quo_q;
  assign zero     = (divisor == '0);

endmodule

`default_nettype wire

// File: rtl/workout_time_calc.sv
// ------------------------------------------------------------------
// workout_time_calc: T = cal*6400 / (7*met_x2*weight*G8) with saturation
// Option: WORKOUT_ROUND_EN rounds to nearest instead of truncating. Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module workout_time_calc
  import workout_pkg::*;
#(
  parameter int unsigned WEIGHT_W = 8,
  parameter int unsigned CAL_W    = 9,
  parameter int unsigned MET_W    = 5,
  parameter int unsigned T_W      = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [WEIGHT_W-1:0] weight_in,
  input  logic [CAL_W-1:0]    cal_in,
  input  logic [MET_W-1:0]    met_x2_in,
  input  logic                gender_in,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [T_W-1:0]      t_out,
  output logic                sat_out,
  output logic                err_out
);

  localparam int unsigned NW = calc_nw(CAL_W);
  localparam int unsigned DW = calc_dw(MET_W, WEIGHT_W);

  state_t state, state_next;

  logic [WEIGHT_W-1:0] weight_q;
  logic [CAL_W-1:0]    cal_q;
  logic [MET_W-1:0]    met_q;
  logic                gender_q;
  logic                err_q;

  logic [3:0]          g8;
  logic [DW-1:0]       den;
  logic [NW-1:0]       num_base;
  logic [NW-1:0]       num;
  logic                div_start;
  logic                div_busy;
  logic                div_done;
  logic                div_zero;
  logic [NW-1:0]       quotient;
  logic                ovf;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      weight_q <= '0;
      cal_q    <= '0;
      met_q    <= '0;
      gender_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      if (state == IDLE && in_valid) begin
        weight_q <= weight_in;
        cal_q    <= cal_in;
        met_q    <= met_x2_in;
        gender_q <= gender_in;
      end
      if (state == PREP) begin
        err_q <= div_zero;
      end
    end
  end

  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    div_start  = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_next = PREP;
      end
      PREP: begin
        div_start  = !div_zero;
        state_next = div_zero ? DONE : DIV;
      end
      DIV: begin
        if (div_done || !div_busy) state_next = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Operands are formed combinationally from the captured inputs and loaded on PREP exit.
  always_comb begin
    g8       = gender_q ? 4'(G8_FEMALE) : 4'(G8_MALE);
    den      = DW'(MET_SCALE) * DW'(met_q) * DW'(weight_q) * DW'(g8);
    num_base = NW'(CAL_SCALE) * NW'(cal_q);
`ifdef WORKOUT_ROUND_EN
    num      = num_base + NW'(den >> 1);
`else
    num      = num_base;
`endif
  end

  seq_divider #(
    .N_W (NW),
    .D_W (DW)
  ) u_div (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (div_start),
    .dividend (num),
    .divisor  (den),
    .busy     (div_busy),
    .done     (div_done),
    .quotient (quotient),
    .zero     (div_zero)
  );

  assign ovf     = |quotient[NW-1:T_W];
  assign t_out   = (err_q || ovf) ? {T_W{1'b1}} : quotient[T_W-1:0];
  assign sat_out = !err_q && ovf;
  assign err_out = err_q;

endmodule

`default_nettype wire

// File: tb/tb_workout_time_calc.sv
// ------------------------------------------------------------------
// tb_workout_time_calc: directed self-checking bench for workout_time_calc
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module tb_workout_time_calc;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] weight_in;
  logic [8:0] cal_in;
  logic [4:0] met_x2_in;
  logic       gender_in;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] t_out;
  logic       sat_out;
  logic       err_out;

  int total = 0;
  int bad   = 0;

`ifdef WORKOUT_ROUND_EN
  localparam int T_CASE3 = 229;
`else
  localparam int T_CASE3 = 228;
`endif

  workout_time_calc dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .weight_in (weight_in),
    .cal_in    (cal_in),
    .met_x2_in (met_x2_in),
    .gender_in (gender_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .t_out     (t_out),
    .sat_out   (sat_out),
    .err_out   (err_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Called just after a falling edge; returns just after the falling edge following acceptance.
  task automatic send(input int w, input int c, input int m, input int g);
    in_valid  = 1'b1;
    weight_in = 8'(w);
    cal_in    = 9'(c);
    met_x2_in = 5'(m);
    gender_in = g[0];
    @(posedge clk);
    @(negedge clk);
    in_valid  = 1'b0;
    weight_in = 8'($urandom);
    cal_in    = 9'($urandom);
    met_x2_in = 5'($urandom);
    gender_in = 1'($urandom);
  endtask

  task automatic expect_result(input string tag, input int et, input int es, input int ee, input int elat);
    int cyc = 0;
    while (out_valid !== 1'b1 && cyc < 60) begin
      @(negedge clk);
      cyc++;
    end
    check({tag, "_lat"}, cyc, elat);
    check({tag, "_t"}, t_out, et);
    check({tag, "_sat"}, sat_out, es);
    check({tag, "_err"}, err_out, ee);
    check({tag, "_rdy_done"}, in_ready, 0);
    if (out_ready) begin
      @(negedge clk);
      check({tag, "_idle"}, {out_valid, in_ready}, 2'b01);
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    weight_in = '0;
    cal_in    = '0;
    met_x2_in = '0;
    gender_in = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_state", {in_ready, out_valid, t_out, sat_out, err_out}, {1'b1, 1'b0, 8'd0, 1'b0, 1'b0});

    // accepted on the first rising edge after release
    rst_n = 1'b1;
    send(70, 100, 8, 0);
    expect_result("c70m", 20, 0, 0, 24);
    send(70, 100, 8, 1);
    expect_result("c70f", 18, 0, 0, 24);
    send(50, 200, 2, 0);
    expect_result("c50_200", T_CASE3, 0, 0, 24);
    send(50, 300, 2, 0);
    expect_result("sat", 255, 1, 0, 24);
    send(0, 100, 8, 0);
    expect_result("err_w0", 255, 0, 1, 1);
    send(70, 100, 0, 1);
    expect_result("err_m0", 255, 0, 1, 1);
    send(255, 1, 31, 1);
    expect_result("maxden", 0, 0, 0, 24);
    send(70, 0, 8, 0);
    expect_result("cal0", 0, 0, 0, 24);
    send(1, 511, 1, 1);
    expect_result("sat_big", 255, 1, 0, 24);

    // back-pressure with a pending request
    out_ready = 1'b0;
    send(70, 100, 8, 1);
    expect_result("bp", 18, 0, 0, 24);
    in_valid  = 1'b1;
    weight_in = 8'd70;
    cal_in    = 9'd100;
    met_x2_in = 5'd8;
    gender_in = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_hold", {out_valid, in_ready, t_out, sat_out, err_out}, {1'b1, 1'b0, 8'd18, 1'b0, 1'b0});
    end
    out_ready = 1'b1;
    @(negedge clk);
    check("bp_release", {out_valid, in_ready}, 2'b01);
    send(70, 100, 8, 0);
    expect_result("bp_pending", 20, 0, 0, 24);

    // reset at DIV cycle 10
    send(50, 200, 2, 0);
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst", {out_valid, in_ready, t_out, sat_out, err_out}, {1'b0, 1'b1, 8'd0, 1'b0, 1'b0});
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      check("post_rst", {out_valid, in_ready}, 2'b01);
    end
    send(70, 100, 8, 0);
    expect_result("after_rst", 20, 0, 0, 24);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
